// File: rtl/risc_exec_pkg.sv
// Shared definitions for the RISC execution core: opcodes, FSM states and
// instruction-field decode usable at any register-address width.
package risc_exec_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_DIV = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_REM = 4'h9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Fields are held at their widest supported size; callers slice to REG_AW/DATA_W.
    typedef struct packed {
        logic [3:0]  op;
        logic [7:0]  rd;
        logic [7:0]  rs1;
        logic [7:0]  rs2;
        logic [31:0] imm;
    } instr_fields_t;

    function automatic instr_fields_t decode_instr(input logic [63:0] instr,
                                                   input int          instr_w,
                                                   input int          reg_aw);
        instr_fields_t f;
        logic [63:0]   fmask;
        logic [63:0]   imask;
        fmask = (64'd1 << reg_aw) - 64'd1;
        imask = (64'd1 << (instr_w - 4 - 2 * reg_aw)) - 64'd1;
        f.op  = 4'((instr >> (instr_w - 4)) & 64'hF);
        f.rd  = 8'((instr >> (instr_w - 4 - reg_aw)) & fmask);
        f.rs1 = 8'((instr >> (instr_w - 4 - 2 * reg_aw)) & fmask);
        f.rs2 = 8'((instr >> (instr_w - 4 - 3 * reg_aw)) & fmask);
        f.imm = 32'(instr & imask);
        return f;
    endfunction

endpackage

// File: rtl/risc_exec_unit_divider.sv
// Restoring sequential divider: one quotient bit per cycle, W iterations total.
// The first iteration is folded into the start cycle so results settle W edges after start.
module risc_seq_divider #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic [W-1:0]  rem_in, quo_in, dvs_in, step_rem, step_quo;
    logic [W:0]    trial;

    always_comb begin
        rem_in   = start ? '0 : rem_q;
        quo_in   = start ? dividend : quo_q;
        dvs_in   = start ? divisor : dvs_q;
        trial    = {rem_in, quo_in[W-1]} - {1'b0, dvs_in};
        // A negative trial restores the shifted partial remainder.
        step_rem = trial[W] ? {rem_in[W-2:0], quo_in[W-1]} : trial[W-1:0];
        step_quo = {quo_in[W-2:0], ~trial[W]};

        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start) begin
            rem_d  = step_rem;
            quo_d  = step_quo;
            dvs_d  = divisor;
            cnt_d  = CW'(W - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/risc_exec_unit.sv
// Parametrised RISC execution core: register file, single-cycle ALU and a sequenced divider.
// Optional hardware multiplier enabled by defining RISC_EXEC_HW_MUL_EN.
module risc_exec_unit
    import risc_exec_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 4,
    parameter int INSTR_W  = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [DATA_W-1:0]  result,
    output logic               result_valid,
    output logic               zero_flag,
    output logic               carry_flag,
    output logic               div_done_flag,
    output logic               div_zero_flag,
    output logic               illegal_flag
);
    localparam int REG_AW = $clog2(NUM_REGS);

    state_e                          state_q, state_d;
    logic [NUM_REGS-1:0][DATA_W-1:0] rf_q, rf_d;
    logic [DATA_W-1:0]               result_q, result_d;
    logic                            result_valid_q, result_valid_d;
    logic                            zero_q, zero_d, carry_q, carry_d;
    logic                            div_done_q, div_done_d, div_zero_q, div_zero_d;
    logic                            illegal_q, illegal_d;
    logic [REG_AW-1:0]               rd_pend_q, rd_pend_d;
    logic                            rem_sel_q, rem_sel_d;

    instr_fields_t     fields;
    logic [3:0]        op;
    logic [REG_AW-1:0] rd, rs1, rs2, wr_rd;
    logic [DATA_W-1:0] a, b, imm_ext, wr_val, quo, rem;
    logic              wr, wr_carry, div_start, div_busy, div_fin;
    logic              unused_sig;

    assign fields     = decode_instr(64'(instr), INSTR_W, REG_AW);
    assign op         = fields.op;
    assign rd         = fields.rd[REG_AW-1:0];
    assign rs1        = fields.rs1[REG_AW-1:0];
    assign rs2        = fields.rs2[REG_AW-1:0];
    assign imm_ext    = DATA_W'(fields.imm);
    assign a          = rf_q[rs1];
    assign b          = rf_q[rs2];
    assign unused_sig = ^{fields, div_busy};

`ifdef RISC_EXEC_HW_MUL_EN
    logic [2*DATA_W-1:0] product;
    assign product = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
`endif

    risc_seq_divider #(.W(DATA_W)) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (div_start),
        .dividend  (a),
        .divisor   (b),
        .busy      (div_busy),
        .done      (div_fin),
        .quotient  (quo),
        .remainder (rem)
    );

    always_comb begin
        state_d        = state_q;
        rf_d           = rf_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        zero_d         = zero_q;
        carry_d        = carry_q;
        div_done_d     = div_done_q;
        div_zero_d     = div_zero_q;
        illegal_d      = illegal_q;
        rd_pend_d      = rd_pend_q;
        rem_sel_d      = rem_sel_q;
        div_start      = 1'b0;
        wr             = 1'b0;
        wr_rd          = rd;
        wr_val         = '0;
        wr_carry       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    div_done_d = 1'b0;
                    div_zero_d = 1'b0;
                    illegal_d  = 1'b0;
                    case (op)
                        OP_ADD: begin
                            wr = 1'b1;
                            {wr_carry, wr_val} = {1'b0, a} + {1'b0, b};
                        end
                        OP_SUB: begin
                            wr       = 1'b1;
                            wr_val   = a - b;
                            wr_carry = (a < b);
                        end
`ifdef RISC_EXEC_HW_MUL_EN
                        OP_MUL: begin
                            wr       = 1'b1;
                            wr_val   = product[DATA_W-1:0];
                            wr_carry = |product[2*DATA_W-1:DATA_W];
                        end
`endif
                        OP_DIV, OP_REM: begin
                            // Divide-by-zero completes at once without touching the divider.
                            if (b == '0) begin
                                wr         = 1'b1;
                                wr_val     = (op == OP_DIV) ? '1 : a;
                                div_zero_d = 1'b1;
                                div_done_d = 1'b1;
                            end else begin
                                div_start = 1'b1;
                                rd_pend_d = rd;
                                rem_sel_d = (op == OP_REM);
                                state_d   = ST_DIV;
                            end
                        end
                        OP_AND: begin wr = 1'b1; wr_val = a & b;   end
                        OP_OR:  begin wr = 1'b1; wr_val = a | b;   end
                        OP_XOR: begin wr = 1'b1; wr_val = a ^ b;   end
                        OP_NOT: begin wr = 1'b1; wr_val = ~a;      end
                        OP_LDI: begin wr = 1'b1; wr_val = imm_ext; end
                        default: begin
                            illegal_d      = 1'b1;
                            result_valid_d = 1'b1;
                        end
                    endcase
                end
            end
            ST_DIV: begin
                if (div_fin) state_d = ST_DONE;
            end
            ST_DONE: begin
                wr         = 1'b1;
                wr_rd      = rd_pend_q;
                wr_val     = rem_sel_q ? rem : quo;
                div_done_d = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (wr) begin
            rf_d[wr_rd]    = wr_val;
            result_d       = wr_val;
            zero_d         = (wr_val == '0);
            carry_d        = wr_carry;
            result_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            rf_q           <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            zero_q         <= 1'b0;
            carry_q        <= 1'b0;
            div_done_q     <= 1'b0;
            div_zero_q     <= 1'b0;
            illegal_q      <= 1'b0;
            rd_pend_q      <= '0;
            rem_sel_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            rf_q           <= rf_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            zero_q         <= zero_d;
            carry_q        <= carry_d;
            div_done_q     <= div_done_d;
            div_zero_q     <= div_zero_d;
            illegal_q      <= illegal_d;
            rd_pend_q      <= rd_pend_d;
            rem_sel_q      <= rem_sel_d;
        end
    end

    assign instr_ready   = (state_q == ST_IDLE);
    assign result        = result_q;
    assign result_valid  = result_valid_q;
    assign zero_flag     = zero_q;
    assign carry_flag    = carry_q;
    assign div_done_flag = div_done_q;
    assign div_zero_flag = div_zero_q;
    assign illegal_flag  = illegal_q;

endmodule

// File: doc/risc_exec_unit.md
# risc_exec_unit

Parametrised execution core for the RISC microcontroller: decodes one instruction per handshake, executes it against an internal register file and reports the result with status flags. It is the successor of the fixed 16-bit/4-register microcontroller datapath. It adds configurable width and register count, a valid/ready instruction handshake, a multi-cycle sequential divider with remainder, and illegal-opcode reporting.

## Interface
- DATA_W, 16: datapath and register width (≥ 8).
- NUM_REGS, 4: register count, power of two; REG_AW = $clog2(NUM_REGS).
- INSTR_W, 16: instruction width; must satisfy INSTR_W ≥ 4 + 3·REG_AW. IMM_W = INSTR_W − 4 − 2·REG_AW (8 at defaults).
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- instr  in  INSTR_W  fields: [MSB-:4] opcode, then rd, then rs1, then rs2 (REG_AW each); imm = low IMM_W bits, zero-extended.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  core can accept; transfer when both high at a rising edge.
- result  out  DATA_W  last value written to rd.
- result_valid  out  1  one-cycle pulse per completed instruction.
- zero_flag, carry_flag  out  1  status of last completed instruction.
- div_done_flag  out  1  set on DIV/REM completion; cleared on next accept.
- div_zero_flag  out  1  set on DIV/REM with rs2 = 0; cleared on next accept.
- illegal_flag  out  1  set on undefined opcode; cleared on next accept.

## Operation
- Opcodes: 0000 ADD, 0001 SUB, 0010 MUL, 0011 DIV, 0100 AND, 0101 OR, 0110 XOR, 0111 NOT (~rs1), 1000 LDI (rd = imm), 1001 REM. All others are illegal.
- Arithmetic is unsigned modulo 2^DATA_W. carry_flag: ADD carry-out; SUB borrow (rs1 < rs2); MUL upper DATA_W bits of the full product ≠ 0; 0 for all other opcodes.
- zero_flag = (written value == 0) for every writing opcode.
- DIV/REM by zero: rd ← all-ones for DIV, rd ← rs1 for REM; div_zero_flag = 1; single-cycle, divider not started.
- Illegal opcode: no register write; result and zero/carry flags hold; illegal_flag = 1; result_valid pulses.
- State machine has three states: IDLE, DIV, DONE.
  - IDLE → DIV on accepting a DIV/REM with nonzero divisor.
  - DIV → DONE after DATA_W iterations, one restoring step per cycle.
  - DONE → IDLE after one cycle, writing rd and pulsing result_valid.
  - All other opcodes complete directly from IDLE.
- instr_ready = 1 only in IDLE.
- Operands are sampled at the accept edge. Register writes complete before the next accept, so back-to-back dependent instructions read updated values without forwarding.
- Reset: all registers and outputs go to 0, instr_ready goes to 1, state goes to IDLE. A reset mid-division aborts with no write.

## Timing
- Single-cycle ops: accepted at edge T; rd, result and flags update at T; result_valid is high during cycle T..T+1. One instruction per cycle is sustained.
- DIV/REM: accepted at edge T; instr_ready is low from T until the edge T+DATA_W+1. At that edge rd and result update and result_valid pulses. instr_ready returns high in the same cycle that result_valid is high. Total latency is DATA_W+1 cycles.
- instr_valid while instr_ready is low is ignored and is not queued.

## Configuration
- RISC_EXEC_HW_MUL_EN: when defined, MUL is a single-cycle DATA_W×DATA_W multiplier as above. When undefined, no multiplier is synthesised and opcode 0010 is treated as illegal (illegal_flag, no write).

## Structure
- Package risc_exec_pkg holds the opcode localparams, the state enum (IDLE, DIV, DONE) and an instruction-field extraction helper parameterised by REG_AW.
- Sub-module risc_seq_divider is the restoring divider, with start, dividend, divisor, busy, done, quotient and remainder. It is instantiated once. The top-level FSM sequences it.

## Test plan
- LDI R0,2 then ADD R1,R0,R0 back-to-back → result 2 then 4; zero 0, carry 0; two consecutive result_valid pulses.
- With R0=2, R1=4: SUB R2,R0,R1 → 0xFFFE, carry 1. SUB R3,R0,R0 → 0, zero 1.
- LDI R0,255; MUL R1,R0,R0 → 0xFE01, carry 0. MUL R2,R1,R1 → 0xFC01, carry 1.
- With R2=100, R1=7: DIV R3,R2,R1 → instr_ready low 17 cycles, result 14, div_done_flag 1. REM R3,R2,R1 → 2.
- DIV R3,R2,R0 with R0=0 → 0xFFFF after 1 cycle, div_zero_flag 1. Then reset_n low during the 5th cycle of a 100/7 DIV → all outputs 0 and instr_ready 1 immediately; R3 reads 0 afterwards.
- Opcode 1111 → illegal_flag 1, result unchanged, no write. Build without RISC_EXEC_HW_MUL_EN: MUL → illegal_flag 1.
